// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the gated-window frequency meter.
// The default clock rate matches the one the clock dividers are built around.
package freq_meter_pkg;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int FLUSH_CYCLES   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by one compare flop.
// Produces a clean registered level and a single-cycle rising-edge strobe.
// Also suitable for debouncing-free button inputs elsewhere in the design.
module sync_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic Async_In,
    output logic Level,
    output logic Rise
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // Synchronize the async input, then keep one extra stage for edge compare
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= Async_In;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign Level = sync_p1;
    assign Rise  = sync_p1 & ~sync_p2;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency counter. Counts synchronized rising edges of Sig_In
// over back-to-back windows of GATE_CYCLES Clk cycles and publishes the count
// (Hz when GATE_CYCLES == CLK_HZ) with a one-cycle valid pulse per window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = 27
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Sig_In,
    input  logic             Enable,
    output logic [CNT_W-1:0] Freq,
    output logic             Freq_Valid,
    output logic             Overflow
);

    localparam int                GATE_W     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [1:0]        FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    meter_state_t      state;
    meter_state_t      state_nxt;
    logic [1:0]        flush_cnt;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_sat;
    logic              flush_run;
    logic              meas_run;
    logic              gate_last;
    logic              strobe;
    logic              level_unused;

    // Saturating increment: the count sticks at CNT_MAX rather than wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
        if (inc && (val != CNT_MAX))
            return val + CNT_W'(1);
        return val;
    endfunction

    // True when this increment would have pushed the count past CNT_MAX
    function automatic logic sat_hit(input logic [CNT_W-1:0] val, input logic inc);
        return inc && (val == CNT_MAX);
    endfunction

    sync_edge_detect u_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .Async_In (Sig_In),
        .Level    (level_unused),
        .Rise     (strobe)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: dropping Enable always aborts back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Enable) state_nxt = FLUSH;
            FLUSH:   if (!Enable) state_nxt = IDLE;
                     else if (flush_cnt == FLUSH_LAST) state_nxt = MEASURE;
            MEASURE: if (!Enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode: counters only run while Enable is still high
    always_comb begin
        flush_run = Enable && (state == FLUSH);
        meas_run  = Enable && (state == MEASURE);
        gate_last = meas_run && (gate_cnt == GATE_LAST);
    end

    // Flush timer lets stale synchronizer contents drain before counting
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            flush_cnt <= '0;
        else if (flush_run && (flush_cnt != FLUSH_LAST))
            flush_cnt <= flush_cnt + 2'd1;
        else
            flush_cnt <= '0;
    end

    // Gate counter wraps on the terminal cycle with no dead cycle between windows
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            gate_cnt <= '0;
        else if (!meas_run || gate_last)
            gate_cnt <= '0;
        else
            gate_cnt <= gate_cnt + GATE_W'(1);
    end

    // Edge counter plus a sticky flag remembering any saturation in this window
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            edge_cnt <= '0;
            edge_sat <= 1'b0;
        end else if (!meas_run || gate_last) begin
            edge_cnt <= '0;
            edge_sat <= 1'b0;
        end else if (strobe) begin
            edge_cnt <= sat_inc(edge_cnt, 1'b1);
            edge_sat <= edge_sat | sat_hit(edge_cnt, 1'b1);
        end
    end

    // Publish result; a strobe on the terminal cycle belongs to the closing window
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Freq       <= '0;
            Freq_Valid <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            Freq_Valid <= gate_last;
            if (gate_last) begin
                Freq     <= sat_inc(edge_cnt, strobe);
                Overflow <= edge_sat | sat_hit(edge_cnt, strobe);
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (CNT_W=8 and CNT_W=4, GATE_CYCLES=100)
// share stimulus. Sig_In rises are logged by cycle; the reference model counts
// the rises whose strobe falls inside each 100-cycle window ending at a pulse.
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int LAT  = 104;   // enable set -> first valid edge

    typedef struct {
        int e;
        int f;
        int o;
    } vrec_t;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       Sig_In = 1'b0;
    logic       Enable = 1'b0;
    logic [7:0] freq8;
    logic       valid8;
    logic       ovf8;
    logic [3:0] freq4;
    logic       valid4;
    logic       ovf4;

    int    tests   = 0;
    int    fails   = 0;
    int    edge_no = 0;
    int    rise_q[$];
    vrec_t vq8[$];
    vrec_t vq4[$];

    freq_meter #(.CLK_HZ(100), .GATE_CYCLES(GATE), .CNT_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Sig_In(Sig_In), .Enable(Enable),
        .Freq(freq8), .Freq_Valid(valid8), .Overflow(ovf8)
    );

    freq_meter #(.CLK_HZ(100), .GATE_CYCLES(GATE), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Sig_In(Sig_In), .Enable(Enable),
        .Freq(freq4), .Freq_Valid(valid4), .Overflow(ovf4)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_no <= edge_no + 1;

    // Log every valid pulse together with the edge it appeared after
    always @(negedge Clk) begin
        if (valid8 === 1'b1) vq8.push_back('{edge_no, int'(freq8), int'(ovf8)});
        if (valid4 === 1'b1) vq4.push_back('{edge_no, int'(freq4), int'(ovf4)});
    end

    // Rises of Sig_In whose strobe cycle (rise edge + 2) lies in the window ending at edge v
    function automatic int model_cnt(input int v);
        int c = 0;
        foreach (rise_q[k])
            if ((rise_q[k] + 2 >= v - GATE) && (rise_q[k] + 2 <= v - 1)) c++;
        return c;
    endfunction

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    function automatic logic sq(input int i, input int per);
        return (i % per) < (per / 2);
    endfunction

    function automatic logic tw(input int i);
        if (i < 2)    return 1'b0;
        if (i <= 100) return ((i - 2) % 10) < 5;
        if (i == 101) return 1'b1;
        if (i < 104)  return 1'b0;
        return ((i - 104) % 10) < 5;
    endfunction

    task automatic tick(input logic v);
        @(posedge Clk);
        #1;
        if (v === 1'b1 && Sig_In !== 1'b1) rise_q.push_back(edge_no);
        Sig_In = v;
    endtask

    task automatic enable_on(output int m);
        @(posedge Clk);
        #1;
        vq8.delete();
        vq4.delete();
        Enable = 1'b1;
        m = edge_no;
    endtask

    task automatic go_idle();
        Enable = 1'b0;
        repeat (10) tick(1'b0);
        vq8.delete();
        vq4.delete();
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Enable = 1'b0;
        Sig_In = 1'b0;
        #12;
        tests++; if (freq8 !== 8'd0)  begin fails++; $display("FAIL reset_freq8: got %0d, want 0", freq8); end
        tests++; if (valid8 !== 1'b0) begin fails++; $display("FAIL reset_valid8: got %b, want 0", valid8); end
        tests++; if (ovf8 !== 1'b0)   begin fails++; $display("FAIL reset_ovf8: got %b, want 0", ovf8); end
        tests++; if (freq4 !== 4'd0)  begin fails++; $display("FAIL reset_freq4: got %0d, want 0", freq4); end
        tests++; if (valid4 !== 1'b0) begin fails++; $display("FAIL reset_valid4: got %b, want 0", valid4); end
        tests++; if (ovf4 !== 1'b0)   begin fails++; $display("FAIL reset_ovf4: got %b, want 0", ovf4); end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (5) tick(1'b0);
    endtask

    task automatic test_period10();
        int m, c;
        enable_on(m);
        for (int i = 1; i <= 420; i++) tick(sq(i - 1, 10));
        tests++;
        if (vq8.size() != 4 || vq4.size() != 4) begin
            fails++; $display("FAIL p10_count: got %0d/%0d pulses, want 4/4", vq8.size(), vq4.size());
        end
        for (int k = 0; k < vq8.size(); k++) begin
            tests++;
            if (vq8[k].e !== m + LAT + GATE * k) begin
                fails++; $display("FAIL p10_time8[%0d]: edge %0d, want %0d", k, vq8[k].e, m + LAT + GATE * k);
            end
            tests++;
            if (vq8[k].f !== 10 || vq8[k].o !== 0) begin
                fails++; $display("FAIL p10_freq8[%0d]: got %0d ovf %0d, want 10 ovf 0", k, vq8[k].f, vq8[k].o);
            end
        end
        for (int k = 0; k < vq4.size(); k++) begin
            c = model_cnt(vq4[k].e);
            tests++;
            if (vq4[k].e !== m + LAT + GATE * k || vq4[k].f !== sat(c, 4) || vq4[k].o !== int'(c > 15)) begin
                fails++; $display("FAIL p10_dut4[%0d]: edge %0d freq %0d ovf %0d, want edge %0d freq %0d ovf %0d",
                                  k, vq4[k].e, vq4[k].f, vq4[k].o, m + LAT + GATE * k, sat(c, 4), int'(c > 15));
            end
        end
        go_idle();
    endtask

    task automatic test_max_rate();
        int m, c;
        enable_on(m);
        for (int i = 1; i <= 520; i++) tick((i <= 304) ? sq(i - 1, 2) : 1'b0);
        tests++;
        if (vq8.size() != 5 || vq4.size() != 5) begin
            fails++; $display("FAIL max_count: got %0d/%0d pulses, want 5/5", vq8.size(), vq4.size());
        end
        for (int k = 0; k < vq8.size(); k++) begin
            c = model_cnt(vq8[k].e);
            tests++;
            if (vq8[k].e !== m + LAT + GATE * k || vq8[k].f !== sat(c, 8) || vq8[k].o !== int'(c > 255)) begin
                fails++; $display("FAIL max_dut8[%0d]: edge %0d freq %0d ovf %0d, want edge %0d freq %0d ovf %0d",
                                  k, vq8[k].e, vq8[k].f, vq8[k].o, m + LAT + GATE * k, sat(c, 8), int'(c > 255));
            end
            if (k < 3 || k == 4) begin
                tests++;
                if (vq8[k].f !== ((k < 3) ? 50 : 0)) begin
                    fails++; $display("FAIL max_const8[%0d]: got %0d, want %0d", k, vq8[k].f, (k < 3) ? 50 : 0);
                end
            end
        end
        for (int k = 0; k < vq4.size(); k++) begin
            c = model_cnt(vq4[k].e);
            tests++;
            if (vq4[k].f !== sat(c, 4) || vq4[k].o !== int'(c > 15)) begin
                fails++; $display("FAIL max_dut4[%0d]: freq %0d ovf %0d, want freq %0d ovf %0d",
                                  k, vq4[k].f, vq4[k].o, sat(c, 4), int'(c > 15));
            end
        end
        go_idle();
    endtask

    task automatic test_cnt_w4();
        int m, c;
        enable_on(m);
        for (int i = 1; i <= 424; i++) tick((i <= 204) ? sq(i - 1, 2) : sq(i - 205, 20));
        tests++;
        if (vq8.size() != 4 || vq4.size() != 4) begin
            fails++; $display("FAIL w4_count: got %0d/%0d pulses, want 4/4", vq8.size(), vq4.size());
        end
        for (int k = 0; k < vq4.size(); k++) begin
            c = model_cnt(vq4[k].e);
            tests++;
            if (vq4[k].e !== m + LAT + GATE * k || vq4[k].f !== sat(c, 4) || vq4[k].o !== int'(c > 15)) begin
                fails++; $display("FAIL w4_model[%0d]: edge %0d freq %0d ovf %0d, want edge %0d freq %0d ovf %0d",
                                  k, vq4[k].e, vq4[k].f, vq4[k].o, m + LAT + GATE * k, sat(c, 4), int'(c > 15));
            end
            if (k == 0 || k == 3) begin
                tests++;
                if (vq4[k].f !== ((k == 0) ? 15 : 5) || vq4[k].o !== ((k == 0) ? 1 : 0)) begin
                    fails++; $display("FAIL w4_const[%0d]: got %0d ovf %0d, want %0d ovf %0d",
                                      k, vq4[k].f, vq4[k].o, (k == 0) ? 15 : 5, (k == 0) ? 1 : 0);
                end
            end
        end
        for (int k = 0; k < vq8.size(); k++) begin
            c = model_cnt(vq8[k].e);
            tests++;
            if (vq8[k].f !== sat(c, 8) || vq8[k].o !== int'(c > 255)) begin
                fails++; $display("FAIL w4_dut8[%0d]: freq %0d ovf %0d, want freq %0d ovf %0d",
                                  k, vq8[k].f, vq8[k].o, sat(c, 8), int'(c > 255));
            end
        end
        go_idle();
    endtask

    task automatic test_terminal_edge();
        int m, c;
        enable_on(m);
        for (int i = 1; i <= 310; i++) tick(tw(i));
        tests++;
        if (vq8.size() != 3 || vq4.size() != 3) begin
            fails++; $display("FAIL term_count: got %0d/%0d pulses, want 3/3", vq8.size(), vq4.size());
        end
        for (int k = 0; k < vq8.size(); k++) begin
            c = model_cnt(vq8[k].e);
            tests++;
            if (vq8[k].e !== m + LAT + GATE * k || vq8[k].f !== sat(c, 8)) begin
                fails++; $display("FAIL term_model8[%0d]: edge %0d freq %0d, want edge %0d freq %0d",
                                  k, vq8[k].e, vq8[k].f, m + LAT + GATE * k, sat(c, 8));
            end
            if (k < 2) begin
                tests++;
                if (vq8[k].f !== ((k == 0) ? 11 : 10)) begin
                    fails++; $display("FAIL term_const8[%0d]: got %0d, want %0d", k, vq8[k].f, (k == 0) ? 11 : 10);
                end
            end
        end
        for (int k = 0; k < vq4.size(); k++) begin
            c = model_cnt(vq4[k].e);
            tests++;
            if (vq4[k].f !== sat(c, 4) || vq4[k].o !== int'(c > 15)) begin
                fails++; $display("FAIL term_dut4[%0d]: freq %0d ovf %0d, want freq %0d ovf %0d",
                                  k, vq4[k].f, vq4[k].o, sat(c, 4), int'(c > 15));
            end
        end
        go_idle();
    endtask

    task automatic test_enable_abort();
        int m, m2, c, want_e;
        m2 = 0;
        enable_on(m);
        for (int i = 1; i <= 283; i++) begin
            tick(sq(i - 1, 10));
            if (i == 164) Enable = 1'b0;
            if (i == 173) begin
                tests++;
                if (freq8 !== 8'd10 || valid8 !== 1'b0 || ovf8 !== 1'b0) begin
                    fails++; $display("FAIL abort_hold: freq %0d valid %b ovf %b, want 10 0 0", freq8, valid8, ovf8);
                end
            end
            if (i == 174) begin
                Enable = 1'b1;
                m2 = edge_no;
            end
        end
        tests++;
        if (vq8.size() != 2 || vq4.size() != 2) begin
            fails++; $display("FAIL abort_count: got %0d/%0d pulses, want 2/2", vq8.size(), vq4.size());
        end
        for (int k = 0; k < vq8.size(); k++) begin
            want_e = (k == 0) ? m + LAT : m2 + LAT + GATE * (k - 1);
            c = model_cnt(vq8[k].e);
            tests++;
            if (vq8[k].e !== want_e || vq8[k].f !== 10 || vq8[k].f !== sat(c, 8)) begin
                fails++; $display("FAIL abort_dut8[%0d]: edge %0d freq %0d, want edge %0d freq 10 (model %0d)",
                                  k, vq8[k].e, vq8[k].f, want_e, sat(c, 8));
            end
        end
        for (int k = 0; k < vq4.size(); k++) begin
            want_e = (k == 0) ? m + LAT : m2 + LAT + GATE * (k - 1);
            c = model_cnt(vq4[k].e);
            tests++;
            if (vq4[k].e !== want_e || vq4[k].f !== sat(c, 4)) begin
                fails++; $display("FAIL abort_dut4[%0d]: edge %0d freq %0d, want edge %0d freq %0d",
                                  k, vq4[k].e, vq4[k].f, want_e, sat(c, 4));
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        int m, r, c;
        enable_on(m);
        for (int i = 1; i <= 150; i++) tick(sq(i - 1, 10));
        tests++;
        if (freq8 !== 8'd10) begin
            fails++; $display("FAIL rmid_pre: freq %0d, want 10", freq8);
        end
        @(posedge Clk);
        #1;
        Sig_In = 1'b0;
        Reset  = 1'b1;
        #1;
        tests++;
        if (freq8 !== 8'd0 || valid8 !== 1'b0 || ovf8 !== 1'b0) begin
            fails++; $display("FAIL rmid_dut8: freq %0d valid %b ovf %b, want 0 0 0", freq8, valid8, ovf8);
        end
        tests++;
        if (freq4 !== 4'd0 || valid4 !== 1'b0 || ovf4 !== 1'b0) begin
            fails++; $display("FAIL rmid_dut4: freq %0d valid %b ovf %b, want 0 0 0", freq4, valid4, ovf4);
        end
        repeat (3) tick(1'b0);
        Reset = 1'b0;
        r = edge_no;
        vq8.delete();
        vq4.delete();
        for (int i = 1; i <= 115; i++) tick(sq(i - 1, 10));
        tests++;
        if (vq8.size() != 1 || vq4.size() != 1) begin
            fails++; $display("FAIL rmid_count: got %0d/%0d pulses, want 1/1", vq8.size(), vq4.size());
        end
        for (int k = 0; k < vq8.size(); k++) begin
            c = model_cnt(vq8[k].e);
            tests++;
            if (vq8[k].e !== r + LAT + GATE * k || vq8[k].f !== 10 || vq8[k].f !== sat(c, 8)) begin
                fails++; $display("FAIL rmid_restart8[%0d]: edge %0d freq %0d, want edge %0d freq 10 (model %0d)",
                                  k, vq8[k].e, vq8[k].f, r + LAT + GATE * k, sat(c, 8));
            end
        end
        for (int k = 0; k < vq4.size(); k++) begin
            c = model_cnt(vq4[k].e);
            tests++;
            if (vq4[k].e !== r + LAT + GATE * k || vq4[k].f !== sat(c, 4)) begin
                fails++; $display("FAIL rmid_restart4[%0d]: edge %0d freq %0d, want edge %0d freq %0d",
                                  k, vq4[k].e, vq4[k].f, r + LAT + GATE * k, sat(c, 4));
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_period10();
        test_max_rate();
        test_cnt_w4();
        test_terminal_edge();
        test_enable_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated-window frequency counter; the measuring counterpart of the team's clock dividers. Where a divider derives a known low rate from Clk, this block takes an unknown external square wave, counts its rising edges over a fixed gate derived from Clk (default 1 s), and reports the count as a frequency in Hz. It sits beside the dividers in the board top level, and its result feeds the display path.

## Interface
- CLK_HZ, 100_000_000: Clk frequency in Hz.
- GATE_CYCLES, CLK_HZ: gate window length in Clk cycles. Default gives 1 s; simulation uses 100.
- CNT_W, 27: width of the edge counter and the result.
- Clk  in  1: system clock.
- Reset  in  1: asynchronous, active-high; clock Clk.
- Sig_In  in  1: asynchronous signal under measurement.
- Enable  in  1: level. High runs back-to-back windows; low stops measurement.
- Freq  out  CNT_W: rising-edge count of the last completed window.
- Freq_Valid  out  1: one-cycle pulse when Freq updates.
- Overflow  out  1: last completed window saturated the counter.

## Operation
- Sig_In passes through a 2-FF synchronizer, then a third FF. A rising-edge strobe is sync2 & ~sync3.
- FSM states:
  - IDLE: gate and edge counters held at 0.
  - FLUSH: 3 cycles, lets the synchronizer settle so no spurious edge is counted.
  - MEASURE.
- FSM transitions:
  - IDLE -> FLUSH when Enable=1.
  - FLUSH -> MEASURE after 3 cycles.
  - MEASURE stays in MEASURE while Enable=1.
  - Any state -> IDLE when Enable=0.
- MEASURE:
  - Gate counter runs 0..GATE_CYCLES-1, then wraps to 0 with no dead cycle.
  - Edge counter increments on each strobe.
  - On the terminal gate cycle (gate==GATE_CYCLES-1):
    - Freq <= edge_cnt + strobe, saturating at 2^CNT_W-1.
    - Overflow <= 1 if saturated, else 0.
    - Freq_Valid <= 1.
    - edge_cnt <= 0.
- Strobe coinciding with the terminal cycle counts in the closing window, not the next one.
- Edge counter saturates at 2^CNT_W-1; it never wraps.
- Enable falling mid-window discards the partial count. Freq and Overflow hold their last values, and no Freq_Valid is issued.
- Maximum measurable rate is CLK_HZ/2: Sig_In must be high and low for at least one Clk each. Faster inputs give undefined counts.
- Freq is in Hz only when GATE_CYCLES==CLK_HZ. Otherwise it is edges per window.

## Timing
- Reset values:
  - Freq=0, Freq_Valid=0, Overflow=0.
  - FSM=IDLE, all counters 0, synchronizer FFs 0.
- Sig_In rising edge to strobe: 3 Clk edges (2 sync + 1 compare).
- Enable rise to first gate cycle: 1 cycle into FLUSH + 3 FLUSH cycles. The first Freq_Valid comes GATE_CYCLES cycles after MEASURE entry.
- Freq, Overflow and Freq_Valid update on the same Clk edge. Freq_Valid is high for exactly one cycle per window, period GATE_CYCLES.
- Freq is stable between valid pulses.
- Reset asserted mid-window returns all state to reset values immediately. After deassertion, the block needs Enable high (or still high) to restart through FLUSH.

## Structure
- Shared package freq_meter_pkg:
  - State enum (IDLE, FLUSH, MEASURE).
  - FLUSH_CYCLES=3.
  - Default CLK_HZ, shared with the clock-divider constants.
- Sub-module sync_edge_detect:
  - 2-FF synchronizer plus edge FF.
  - Ports: Clk, Reset, async in, registered level out, rise strobe out.
  - Reusable for buttons elsewhere in the design.
- Top level holds the FSM, gate counter, saturating edge counter and output registers.

## Test plan
All scenarios use GATE_CYCLES=100, CNT_W=8.
- Sig_In period 10 Clk (5 high/5 low), Enable=1 -> each Freq_Valid shows Freq=10, Overflow=0, and pulses are exactly 100 cycles apart.
- Sig_In period 2 Clk (max rate) -> Freq=50 each window. Then Sig_In held low -> next window Freq=0.
- Sig_In edge timed so its strobe lands on gate==99 -> counted in the closing window (e.g. 11 instead of 10), and the next window is unaffected.
- CNT_W=4 with period 2 -> Freq=15, Overflow=1. Period drops to 20 -> next window Freq=5, Overflow=0.
- Enable dropped at gate==60 and raised 10 cycles later -> no Freq_Valid for the aborted window, Freq holds its old value, and the next valid comes 4+100 cycles after re-enable.
- Reset pulsed mid-window with Freq=10 -> Freq=0, Freq_Valid=0, Overflow=0 immediately. Measurement restarts through FLUSH.
